eth_rx_fcs_check: RTL and testbench

Receive-side Ethernet FCS checker and stripper for the 32-bit MAC datapath. It sits between the RX lane aligner and the RX FIFO, as the counterpart of the TX-side CRC32 generator. It runs CRC-32 over every byte of a frame, including the trailing 4-byte FCS, and removes the FCS from the output stream. On the last output beat it flags good, bad-FCS and runt status, and it keeps saturating good/bad frame counters.

---
 rtl/eth_fcs_pkg.sv | 27 ++
 rtl/eth_rx_fcs_check_crc.sv | 24 ++
 rtl/eth_rx_fcs_check.sv | 172 +++++++++++++++++
 tb/tb_eth_rx_fcs_check.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_fcs_pkg.sv
// Shared constants, byte-wise reflected CRC-32 step and FSM state type
// for the receive-side FCS checker.
package eth_fcs_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } fcs_state_e;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data_byte);
        logic [31:0] c;
        c = crc ^ {24'h000000, data_byte};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_rx_fcs_check_crc.sv
// Combinational CRC-32 update over the keep-enabled bytes of one 32-bit beat,
// byte 0 first.
module crc32_rx_d32
    import eth_fcs_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [31:0] data,
    input  logic [3:0]  keep,
    output logic [31:0] crc_out
);

    // Chain up to four byte steps; disabled lanes pass the register through.
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 4; i++) begin
            if (keep[i]) begin
                crc_out = crc32_byte(crc_out, data[8*i +: 8]);
            end else begin
                crc_out = crc_out;
            end
        end
    end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Receive FCS checker/stripper: CRC over the whole frame, one-beat hold to drop
// the trailing FCS, status on the last payload beat and saturating frame counters.
module eth_rx_fcs_check
    import eth_fcs_pkg::*;
#(
    parameter int unsigned MIN_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_keep,
    input  logic        in_last,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_last,
    output logic        out_good,
    output logic        out_bad_fcs,
    output logic        out_runt,
    output logic [31:0] frames_ok,
    output logic [31:0] frames_bad
);

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
    endfunction

    fcs_state_e  state_q, state_d;
    logic [31:0] crc_q, crc_d, crc_next_s;
    logic [31:0] hold_q, hold_d;
    logic [15:0] cnt_q, cnt_d, cnt_next_s;
    logic [16:0] cnt_sum_s;
    logic [3:0]  keep_eff_s;
    logic [2:0]  nbytes_s;
    logic        fcs_ok_s, runt_s;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [3:0]  out_keep_q, out_keep_d;
    logic        out_last_q, out_last_d;
    logic        out_good_q, out_good_d;
    logic        out_bad_q, out_bad_d;
    logic        out_runt_q, out_runt_d;
    logic [31:0] frames_ok_q, frames_ok_d;
    logic [31:0] frames_bad_q, frames_bad_d;

    // A short keep on a non-final beat is illegal and is widened to a full beat.
    assign keep_eff_s = in_last ? in_keep : 4'hF;
    assign nbytes_s   = {2'b00, keep_eff_s[0]} + {2'b00, keep_eff_s[1]}
                      + {2'b00, keep_eff_s[2]} + {2'b00, keep_eff_s[3]};
    assign cnt_sum_s  = {1'b0, cnt_q} + {14'h0000, nbytes_s};
    assign cnt_next_s = cnt_sum_s[16] ? 16'hFFFF : cnt_sum_s[15:0];
    assign fcs_ok_s   = (crc_next_s == CRC32_RESIDUE);
    assign runt_s     = (MIN_BYTES != 32'd0) && ({16'h0000, cnt_next_s} < MIN_BYTES);

    crc32_rx_d32 u_crc (
        .crc_in  (crc_q),
        .data    (in_data),
        .keep    (keep_eff_s),
        .crc_out (crc_next_s)
    );

    // Next-state, hold register, output beat and counter computation.
    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        hold_d       = hold_q;
        cnt_d        = cnt_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_keep_d   = 4'h0;
        out_last_d   = 1'b0;
        out_good_d   = 1'b0;
        out_bad_d    = 1'b0;
        out_runt_d   = 1'b0;
        frames_ok_d  = frames_ok_q;
        frames_bad_d = frames_bad_q;

        if (in_valid) begin
            if (in_last) begin
                state_d     = ST_IDLE;
                crc_d       = CRC32_INIT;
                cnt_d       = 16'h0000;
                out_valid_d = 1'b1;
                out_last_d  = 1'b1;
                if (state_q == ST_HOLD) begin
                    out_data_d = hold_q;
                    out_keep_d = in_keep;
                    out_good_d = fcs_ok_s & ~runt_s;
                    out_bad_d  = ~fcs_ok_s;
                    out_runt_d = runt_s;
                end else begin
                    // A frame of four bytes or fewer cannot even hold an FCS.
                    out_data_d = 32'h00000000;
                    out_keep_d = 4'h0;
                    out_good_d = 1'b0;
                    out_bad_d  = 1'b1;
                    out_runt_d = 1'b1;
                end
            end else begin
                state_d = ST_HOLD;
                crc_d   = crc_next_s;
                cnt_d   = cnt_next_s;
                hold_d  = in_data;
                if (state_q == ST_HOLD) begin
                    out_valid_d = 1'b1;
                    out_data_d  = hold_q;
                    out_keep_d  = 4'hF;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
        end else begin
            state_d = state_q;
        end

        if (out_valid_d && out_last_d) begin
            if (out_good_d) begin
                frames_ok_d = sat_inc32(frames_ok_q);
            end else begin
                frames_bad_d = sat_inc32(frames_bad_q);
            end
        end else begin
            frames_ok_d = frames_ok_q;
        end
    end

    // State, CRC, hold, output and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            crc_q        <= CRC32_INIT;
            hold_q       <= 32'h00000000;
            cnt_q        <= 16'h0000;
            out_valid_q  <= 1'b0;
            out_data_q   <= 32'h00000000;
            out_keep_q   <= 4'h0;
            out_last_q   <= 1'b0;
            out_good_q   <= 1'b0;
            out_bad_q    <= 1'b0;
            out_runt_q   <= 1'b0;
            frames_ok_q  <= 32'h00000000;
            frames_bad_q <= 32'h00000000;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            hold_q       <= hold_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            out_good_q   <= out_good_d;
            out_bad_q    <= out_bad_d;
            out_runt_q   <= out_runt_d;
            frames_ok_q  <= frames_ok_d;
            frames_bad_q <= frames_bad_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_keep    = out_keep_q;
    assign out_last    = out_last_q;
    assign out_good    = out_good_q;
    assign out_bad_fcs = out_bad_q;
    assign out_runt    = out_runt_q;
    assign frames_ok   = frames_ok_q;
    assign frames_bad  = frames_bad_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench: one checker with the runt check disabled and one with a
// 64-byte minimum, both fed the same frames.
module tb_eth_rx_fcs_check;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic [3:0]  in_keep = 4'h0;
    logic        in_last = 1'b0;

    logic        o0_valid, o0_last, o0_good, o0_bad, o0_runt;
    logic [31:0] o0_data, o0_ok, o0_nok;
    logic [3:0]  o0_keep;
    logic        o1_valid, o1_last, o1_good, o1_bad, o1_runt;
    logic [31:0] o1_data, o1_ok, o1_nok;
    logic [3:0]  o1_keep;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx0_q[$];
    logic [7:0] rx1_q[$];
    logic [2:0] st0_q[$];
    logic [2:0] st1_q[$];

    always #5 clk = ~clk;

    eth_rx_fcs_check #(.MIN_BYTES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_keep(in_keep), .in_last(in_last), .out_valid(o0_valid), .out_data(o0_data),
        .out_keep(o0_keep), .out_last(o0_last), .out_good(o0_good), .out_bad_fcs(o0_bad),
        .out_runt(o0_runt), .frames_ok(o0_ok), .frames_bad(o0_nok)
    );

    eth_rx_fcs_check #(.MIN_BYTES(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_keep(in_keep), .in_last(in_last), .out_valid(o1_valid), .out_data(o1_data),
        .out_keep(o1_keep), .out_last(o1_last), .out_good(o1_good), .out_bad_fcs(o1_bad),
        .out_runt(o1_runt), .frames_ok(o1_ok), .frames_bad(o1_nok)
    );

    // Collect output bytes and end-of-frame status of both instances.
    always @(negedge clk) begin
        if (o0_valid) begin
            for (int i = 0; i < 4; i++) if (o0_keep[i]) rx0_q.push_back(o0_data[8*i +: 8]);
            if (o0_last) st0_q.push_back({o0_good, o0_bad, o0_runt});
        end
        if (o1_valid) begin
            for (int i = 0; i < 4; i++) if (o1_keep[i]) rx1_q.push_back(o1_data[8*i +: 8]);
            if (o1_last) st1_q.push_back({o1_good, o1_bad, o1_runt});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_status(input int len, input bit ok, input int min_b);
        logic r;
        if (len <= 4) return 3'b011;
        r = (min_b != 0) && (len < min_b);
        return {ok && !r, !ok, r};
    endfunction

    task automatic start_check();
        rx0_q.delete(); rx1_q.delete(); st0_q.delete(); st1_q.delete(); exp_q.delete();
    endtask

    // Generated frame: payload pattern plus standard CRC-32 FCS, LSB first.
    task automatic build_frame(input int len, input bit corrupt);
        logic [31:0] crc;
        logic [7:0]  b;
        tx_q.delete();
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < len - 4; i++) begin
            b = 8'(i * 7 + 3 + len);
            tx_q.push_back(b);
            exp_q.push_back(b);
            crc = crc ^ {24'h0, b};
            for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end
        crc = ~crc;
        for (int j = 0; j < 4; j++) tx_q.push_back(crc[8*j +: 8]);
        if (corrupt) tx_q[len-1] = tx_q[len-1] ^ 8'h01;
    endtask

    // "123456789" followed by its FCS CBF43926 sent as 26 39 F4 <last>.
    task automatic build_123(input logic [7:0] last_b);
        tx_q.delete();
        for (int i = 0; i < 9; i++) begin
            tx_q.push_back(8'(8'h31 + i));
            exp_q.push_back(8'(8'h31 + i));
        end
        tx_q.push_back(8'h26); tx_q.push_back(8'h39); tx_q.push_back(8'hF4); tx_q.push_back(last_b);
    endtask

    task automatic drive_frame(input int gap_mod, input int max_beats);
        int n, nb;
        n = tx_q.size();
        nb = (n + 3) / 4;
        for (int b = 0; b < nb; b++) begin
            if (max_beats > 0 && b >= max_beats) break;
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data = 32'h0;
            in_keep = 4'h0;
            for (int j = 0; j < 4; j++) begin
                if (4*b + j < n) begin
                    in_data[8*j +: 8] = tx_q[4*b + j];
                    in_keep[j] = 1'b1;
                end
            end
            in_last = (b == nb - 1);
            if (gap_mod > 0 && (b % gap_mod) == 1 && b != nb - 1) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; in_keep = 4'h0;
    endtask

    task automatic wait_status(input string tag, input int n);
        for (int c = 0; c < 60 && !(st0_q.size() >= n && st1_q.size() >= n); c++) @(posedge clk);
        repeat (2) @(posedge clk);
        check_eq({tag, "_nlast0"}, st0_q.size(), n);
        check_eq({tag, "_nlast1"}, st1_q.size(), n);
    endtask

    task automatic check_status(input string tag, input int len, input bit ok);
        logic [2:0] s0, s1;
        s0 = (st0_q.size() > 0) ? st0_q.pop_front() : 3'bxxx;
        s1 = (st1_q.size() > 0) ? st1_q.pop_front() : 3'bxxx;
        check_eq({tag, "_st_min0"}, {29'h0, s0}, {29'h0, exp_status(len, ok, 0)});
        check_eq({tag, "_st_min64"}, {29'h0, s1}, {29'h0, exp_status(len, ok, 64)});
    endtask

    task automatic check_payload(input string tag);
        int err0, err1;
        err0 = 0; err1 = 0;
        check_eq({tag, "_len0"}, rx0_q.size(), exp_q.size());
        check_eq({tag, "_len1"}, rx1_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= rx0_q.size() || rx0_q[i] !== exp_q[i]) err0++;
            if (i >= rx1_q.size() || rx1_q[i] !== exp_q[i]) err1++;
        end
        check_eq({tag, "_bytes0"}, err0, 0);
        check_eq({tag, "_bytes1"}, err1, 0);
    endtask

    task automatic check_counters(input string tag, input int ok0, input int bad0, input int ok1, input int bad1);
        check_eq({tag, "_ok_min0"}, o0_ok, ok0);
        check_eq({tag, "_bad_min0"}, o0_nok, bad0);
        check_eq({tag, "_ok_min64"}, o1_ok, ok1);
        check_eq({tag, "_bad_min64"}, o1_nok, bad1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", {o1_valid, o0_valid}, 2'b00);
        check_eq("rst_keep_last", {o0_keep, o0_last, o0_good, o0_bad, o0_runt}, 8'h00);
        check_eq("rst_data", o0_data, 32'h0);
        check_counters("rst", 0, 0, 0, 0);
        rst_n = 1'b1;

        // Known CRC vector, good and one-bit-corrupted
        start_check(); build_123(8'hCB); drive_frame(0, 0); go_idle();
        wait_status("f123", 1); check_payload("f123"); check_status("f123", 13, 1'b1);
        check_counters("f123", 1, 0, 0, 1);

        start_check(); build_123(8'hCA); drive_frame(0, 0); go_idle();
        wait_status("f123bad", 1); check_payload("f123bad"); check_status("f123bad", 13, 1'b0);
        check_counters("f123bad", 1, 1, 0, 2);

        // Minimum-length boundary
        start_check(); build_frame(64, 1'b0); drive_frame(0, 0); go_idle();
        wait_status("f64", 1); check_payload("f64"); check_status("f64", 64, 1'b1);

        start_check(); build_frame(60, 1'b0); drive_frame(0, 0); go_idle();
        wait_status("f60", 1); check_payload("f60"); check_status("f60", 60, 1'b1);

        // Single full beat with last: status beat exactly one cycle later
        start_check(); build_frame(4, 1'b0); drive_frame(0, 0);
        @(posedge clk); #1;
        check_eq("single_beat", {o0_valid, o0_last, o0_keep, o0_good, o0_bad, o0_runt}, 9'b1_1_0000_011);
        in_valid = 1'b0; in_last = 1'b0; in_keep = 4'h0;
        @(posedge clk); #1;
        check_eq("single_after", {o1_valid, o0_valid}, 2'b00);
        wait_status("f4", 1); check_payload("f4"); check_status("f4", 4, 1'b1);

        // Back-to-back frames, valid gaps inside the second
        start_check();
        build_frame(22, 1'b0); drive_frame(0, 0);
        build_frame(68, 1'b0); drive_frame(3, 0);
        go_idle();
        wait_status("b2b", 2); check_payload("b2b");
        check_status("b2b_a", 22, 1'b1); check_status("b2b_b", 68, 1'b1);
        check_counters("b2b", 5, 2, 2, 5);

        // Reset in the middle of a frame
        start_check(); build_frame(64, 1'b0); drive_frame(0, 3);
        check_eq("pre_rst_valid", {o1_valid, o0_valid}, 2'b11);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", {o1_valid, o0_valid}, 2'b00);
        check_counters("rst_mid", 0, 0, 0, 0);
        in_valid = 1'b0; in_last = 1'b0; in_keep = 4'h0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk);

        start_check(); build_frame(64, 1'b0); drive_frame(0, 0); go_idle();
        wait_status("post_rst", 1); check_payload("post_rst"); check_status("post_rst", 64, 1'b1);
        check_counters("post_rst", 1, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
